cs_loader: RTL

Control-store loader and handoff controller for the ECLair microsequencer. After reset it copies every word of the microcode EPROM into the microcode RAM, then optionally reads the RAM back and compares it against the EPROM. On success it asserts `cs_ready`, which gates the CPU reset and clock select and hands RAM addressing to the sequencer. This replaces the ad-hoc copier logic and the `top_of_cs`/JK flip-flop ready detection in the top level.

---
 rtl/cs_loader_pkg.sv | 21 ++
 rtl/cs_loader_counter.sv | 24 ++
 rtl/cs_loader.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cs_loader_pkg.sv
// Shared constants for the control-store loader: state encodings and default geometry.
package cs_loader_pkg;

  // Loader state encodings (3-bit, legacy-compatible constants)
  localparam logic [2:0] CSL_FETCH  = 3'd0;
  localparam logic [2:0] CSL_WRITE  = 3'd1;
  localparam logic [2:0] CSL_HOLD   = 3'd2;
  localparam logic [2:0] CSL_VERIFY = 3'd3;
  localparam logic [2:0] CSL_DONE   = 3'd4;
  localparam logic [2:0] CSL_ERROR  = 3'd5;

  // Default control-store geometry
  localparam int unsigned CS_ADDR_WIDTH = 8;
  localparam int unsigned CS_DATA_WIDTH = 64;

  // Width of the access-wait counter; at least one bit even when rom_wait is 1
  function automatic int unsigned wait_width(input int unsigned rom_wait);
    return (rom_wait > 1) ? $clog2(rom_wait) : 1;
  endfunction

endpackage

// File: rtl/cs_loader_counter.sv
// Control-store address counter: async clear, synchronous load of a preset value, count enable.
module cs_loader_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] preset,
  input  logic             ce,
  output logic [WIDTH-1:0] count
);

  // Load has priority over increment so a terminating pass can clear in one edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= preset;
    end else if (ce) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/cs_loader.sv
// Control-store loader: copies EPROM into microcode RAM, optionally verifies it, then hands
// RAM addressing to the sequencer and raises cs_ready.
module cs_loader
  import cs_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = CS_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = CS_DATA_WIDTH,
  parameter int unsigned ROM_WAIT   = 1,
  parameter int unsigned VERIFY     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reload,
  input  logic [ADDR_WIDTH-1:0] seq_addr,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  ram__w,
  output logic                  cs_ready,
  output logic                  cs_error,
  output logic [ADDR_WIDTH-1:0] err_addr
);

  localparam int unsigned WaitW = wait_width(ROM_WAIT);

  logic [2:0]            state_q, state_d;
  logic [WaitW-1:0]      wait_q, wait_d;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic                  cnt_load, cnt_ce;
  logic                  wait_last, addr_last;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic                  ram_w_n_d, ready_d, error_d;
  logic [ADDR_WIDTH-1:0] err_addr_d;

  assign wait_last = (wait_q == WaitW'(ROM_WAIT - 1));
  assign addr_last = &ld_addr;

  cs_loader_counter #(
    .WIDTH (ADDR_WIDTH)
  ) u_addr_cnt (
    .clk    (clk),
    .reset  (reset),
    .load   (cnt_load),
    .preset ({ADDR_WIDTH{1'b0}}),
    .ce     (cnt_ce),
    .count  (ld_addr)
  );

  // Next-state, counter control and registered-output next values
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    cnt_load   = 1'b0;
    cnt_ce     = 1'b0;
    wdata_d    = ram_wdata;
    ram_w_n_d  = 1'b1;
    ready_d    = cs_ready;
    error_d    = cs_error;
    err_addr_d = err_addr;
    case (state_q)
      CSL_FETCH: begin
        if (wait_last) begin
          wait_d    = '0;
          wdata_d   = rom_data;
          ram_w_n_d = 1'b0;
          state_d   = CSL_WRITE;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      CSL_WRITE: begin
        state_d = CSL_HOLD;
      end
      CSL_HOLD: begin
        if (addr_last) begin
          cnt_load = 1'b1;
          if (VERIFY != 0) begin
            state_d = CSL_VERIFY;
          end else begin
            state_d = CSL_DONE;
            ready_d = 1'b1;
          end
        end else begin
          cnt_ce  = 1'b1;
          state_d = CSL_FETCH;
        end
      end
      CSL_VERIFY: begin
        if (wait_last) begin
          wait_d = '0;
          // Case inequality so X/Z read-back is treated as a mismatch in simulation
          if (ram_rdata !== rom_data) begin
            error_d    = 1'b1;
            err_addr_d = ld_addr;
            state_d    = CSL_ERROR;
          end else if (addr_last) begin
            cnt_load = 1'b1;
            ready_d  = 1'b1;
            state_d  = CSL_DONE;
          end else begin
            cnt_ce = 1'b1;
          end
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      CSL_DONE, CSL_ERROR: begin
        if (reload) begin
          cnt_load = 1'b1;
          ready_d  = 1'b0;
          error_d  = 1'b0;
          wait_d   = '0;
          state_d  = CSL_FETCH;
        end
      end
      default: begin
        cnt_load = 1'b1;
        wait_d   = '0;
        state_d  = CSL_FETCH;
      end
    endcase
  end

  // State and registered outputs; reset releases the write strobe immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= CSL_FETCH;
      wait_q    <= '0;
      ram_wdata <= '0;
      ram__w    <= 1'b1;
      cs_ready  <= 1'b0;
      cs_error  <= 1'b0;
      err_addr  <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      ram_wdata <= wdata_d;
      ram__w    <= ram_w_n_d;
      cs_ready  <= ready_d;
      cs_error  <= error_d;
      err_addr  <= err_addr_d;
    end
  end

  // Address select: sequencer owns the RAM once ready, error freezes it on the bad word
  always_comb begin
    ram_addr = ld_addr;
    rom_addr = ld_addr;
    if (state_q == CSL_DONE) begin
      ram_addr = seq_addr;
      rom_addr = '0;
    end else if (state_q == CSL_ERROR) begin
      ram_addr = err_addr;
    end
  end

endmodule
